// File: rtl/btn_cond.sv
// btn_cond: front-panel button conditioning on the system clock.
// Each raw button is synchronised, sampled on a slow tick and debounced.
// The block then produces clean levels and one-clk press/release pulses.
// Optional auto-repeat pulses are built only when BTN_AUTOREPEAT_EN is defined.
// Without that macro, btn_repeat is tied to zero.
module btn_cond #(
    parameter int                 N_BTN        = 5,
    parameter int                 TICK_DIV     = 16,
    parameter int                 STABLE_TICKS = 4,
    parameter int                 REPEAT_DELAY = 32,
    parameter int                 REPEAT_RATE  = 8,
    parameter logic [N_BTN-1:0]   REPEAT_MASK  = 5'b00110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic             tick,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int SW = $clog2(STABLE_TICKS + 1);

    logic [N_BTN-1:0]    sync_a;
    logic [N_BTN-1:0]    sync_b;
    logic [TICK_DIV-1:0] div_cnt;
    logic [SW-1:0]       stab_cnt [N_BTN];
    logic [N_BTN-1:0]    flip;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    // Free-running divider; the sample tick is its all-ones state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_cnt <= '0;
        else     div_cnt <= div_cnt + 1'b1;
    end

    assign tick = &div_cnt;

    // A bit flips on the tick that would bring its stability count to STABLE_TICKS.
    always_comb begin
        flip = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick && (sync_b[i] != btn_level[i]) &&
                (stab_cnt[i] == SW'(STABLE_TICKS - 1)))
                flip[i] = 1'b1;
        end
    end

    // Debounced level, stability counters and registered edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) stab_cnt[i] <= '0;
        end else begin
            btn_level   <= btn_level ^ flip;
            btn_press   <= flip & ~btn_level;
            btn_release <= flip & btn_level;
            for (int i = 0; i < N_BTN; i++) begin
                if (tick) begin
                    if ((sync_b[i] == btn_level[i]) || flip[i])
                        stab_cnt[i] <= '0;
                    else if (stab_cnt[i] != SW'(STABLE_TICKS))
                        stab_cnt[i] <= stab_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0]    rep_cnt [N_BTN];
    logic [N_BTN-1:0] rep_phase;
    logic [N_BTN-1:0] rep_fire;

    // Repeat fires when the tick reaches the phase target.
    // A release debounced on the same tick suppresses the repeat.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (REPEAT_MASK[i] && tick && btn_level[i] && !flip[i]) begin
                if (!rep_phase[i] && (rep_cnt[i] == RW'(REPEAT_DELAY - 1)))
                    rep_fire[i] = 1'b1;
                else if (rep_phase[i] && (rep_cnt[i] == RW'(REPEAT_RATE - 1)))
                    rep_fire[i] = 1'b1;
            end
        end
    end

    // Repeat counters count ticks while held.
    // They clear while released, on the press edge, and on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_repeat <= '0;
            rep_phase  <= '0;
            for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
        end else begin
            btn_repeat <= rep_fire;
            for (int i = 0; i < N_BTN; i++) begin
                if (!REPEAT_MASK[i] || !btn_level[i] || flip[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b1;
                end else if (tick) begin
                    rep_cnt[i]   <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    // Repeat configuration is irrelevant when auto-repeat is not built.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_RATE[0]};
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_btn_cond.sv
// Directed testbench for btn_cond with a fast tick (every 4 clk).
// Settings: STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2.
// Repeat expectations follow whether BTN_AUTOREPEAT_EN is defined.
module tb_btn_cond;
    localparam int NB = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic          tick;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_n   = 0;
    int press_n  [NB];
    int rel_n    [NB];
    int rep_n    [NB];
    int press_cyc[NB];
    int rel_cyc  [NB];
    int rise_cyc [NB];
    logic [NB-1:0] lvl_prev = '0;
    int rep_q[$];

    btn_cond #(
        .N_BTN(NB), .TICK_DIV(2), .STABLE_TICKS(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2), .REPEAT_MASK(5'b00110)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .tick(tick),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder sampled on the falling edge.
    always @(negedge clk) begin
        if (tick) tick_n++;
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i])   begin press_n[i]++; press_cyc[i] = cyc; end
            if (btn_release[i]) begin rel_n[i]++;   rel_cyc[i]   = cyc; end
            if (btn_repeat[i])  begin rep_n[i]++; if (i == 2) rep_q.push_back(cyc); end
            if (btn_level[i] && !lvl_prev[i]) rise_cyc[i] = cyc;
        end
        lvl_prev = btn_level;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_lat(input string tag, input int lat);
        check_eq($sformatf("%s lat=%0d in [11,14]", tag, lat),
                 (lat >= 11 && lat <= 14) ? 1 : 0, 1);
    endtask

    initial begin
        int e, p0, p1, r0, q0, t0, rp0, nexp, pp, rr;

        rst    = 1'b1;
        btn_in = '0;
        step(3);
        check_eq("rst_tick",    int'(tick), 0);
        check_eq("rst_level",   int'(btn_level), 0);
        check_eq("rst_press",   int'(btn_press), 0);
        check_eq("rst_release", int'(btn_release), 0);
        check_eq("rst_repeat",  int'(btn_repeat), 0);
        rst = 1'b0;

        // Tick every 4 clk.
        t0 = tick_n;
        step(40);
        check_eq("tick_count_40clk", tick_n - t0, 10);

        // Clean press and release on an unmasked button.
        p0 = press_n[0]; r0 = rel_n[0]; rp0 = rep_n[0];
        e = cyc; btn_in[0] = 1'b1;
        step(60);
        check_lat("b0_press", press_cyc[0] - e);
        check_eq("b0_press_count", press_n[0] - p0, 1);
        check_eq("b0_press_on_level_edge", press_cyc[0], rise_cyc[0]);
        check_eq("b0_level_high", int'(btn_level[0]), 1);
        e = cyc; btn_in[0] = 1'b0;
        step(20);
        check_lat("b0_release", rel_cyc[0] - e);
        check_eq("b0_release_count", rel_n[0] - r0, 1);
        check_eq("b0_level_low", int'(btn_level[0]), 0);
        check_eq("b0_no_repeat", rep_n[0] - rp0, 0);

        // Bounce: toggle every 5 clk for 60 clk; never stable for 3 ticks.
        p0 = press_n[1]; r0 = rel_n[1];
        for (int k = 0; k < 12; k++) begin
            btn_in[1] = ~btn_in[1];
            step(5);
        end
        step(20);
        check_eq("b1_bounce_press", press_n[1] - p0, 0);
        check_eq("b1_bounce_release", rel_n[1] - r0, 0);
        check_eq("b1_bounce_level", int'(btn_level[1]), 0);

        // Auto-repeat on a masked button held 100 clk.
        p0 = press_n[2]; r0 = rel_n[2]; rp0 = rep_n[2]; q0 = rep_q.size();
        e = cyc; btn_in[2] = 1'b1;
        step(100);
        btn_in[2] = 1'b0;
        step(30);
        pp = press_cyc[2]; rr = rel_cyc[2];
        check_lat("b2_press", pp - e);
        check_eq("b2_press_count", press_n[2] - p0, 1);
        check_eq("b2_release_count", rel_n[2] - r0, 1);
        check_eq("b2_hold_span", rr - pp, 100);
`ifdef BTN_AUTOREPEAT_EN
        // Repeats at press+20, then every 8.
        // The one due at press+100 coincides with release and is dropped.
        nexp = 10;
        check_eq("b2_repeat_count", rep_n[2] - rp0, nexp);
        if (rep_q.size() >= q0 + nexp) begin
            check_eq("b2_first_repeat", rep_q[q0] - pp, 20);
            check_eq("b2_second_repeat", rep_q[q0 + 1] - pp, 28);
            check_eq("b2_last_repeat", rep_q[q0 + nexp - 1] - pp, 92);
        end
`else
        nexp = 0;
        check_eq("b2_repeat_count", rep_n[2] - rp0, nexp);
`endif

        // Simultaneous press on two buttons.
        p0 = press_n[3]; p1 = press_n[4];
        btn_in[4:3] = 2'b11;
        step(20);
        check_eq("b3_press_count", press_n[3] - p0, 1);
        check_eq("b4_press_count", press_n[4] - p1, 1);
        check_eq("b34_same_cycle", press_cyc[3], press_cyc[4]);
        r0 = rel_n[3];
        btn_in[4:3] = 2'b00;
        step(20);
        check_eq("b3_release_count", rel_n[3] - r0, 1);
        check_eq("b34_release_same", rel_cyc[3], rel_cyc[4]);
        check_eq("b34_no_repeat", rep_n[3] + rep_n[4], 0);

        // Reset while button 2 is held with its level high.
        btn_in[2] = 1'b1;
        step(20);
        check_eq("b2_held_level", int'(btn_level[2]), 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_eq("async_rst_tick",  int'(tick), 0);
        check_eq("async_rst_level", int'(btn_level), 0);
        check_eq("async_rst_press", int'(btn_press), 0);
        check_eq("async_rst_rel",   int'(btn_release), 0);
        check_eq("async_rst_rep",   int'(btn_repeat), 0);
        step(2);
        p0 = press_n[2];
        e = cyc; rst = 1'b0;
        step(16);
        check_eq("b2_repress_count", press_n[2] - p0, 1);
        check_lat("b2_repress", press_cyc[2] - e);
        btn_in[2] = 1'b0;
        step(20);
        check_eq("b2_final_level", int'(btn_level[2]), 0);
`ifndef BTN_AUTOREPEAT_EN
        check_eq("no_repeat_any", rep_n[0] + rep_n[1] + rep_n[2] + rep_n[3] + rep_n[4], 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
